// File: rtl/sat_problem_loader_if.sv
// Command stream interface for sat_problem_loader.
// Carries the 32-bit valid/ready command words from the host/DMA.
//   s_valid : word valid (host -> loader)
//   s_data  : command word (host -> loader)
//   s_ready : loader accepts the word this cycle (loader -> host)
interface sat_problem_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sat_problem_loader.sv
// Streaming front-end and run sequencer for the WalkSAT Controller/Datapath.
// Unpacks a 32-bit command stream into CT / ATT / UCB load writes and runs
// the solver (start pulse, wait for done, report result and cycle count).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd (slave)              command stream s_valid / s_data / s_ready
//   ct_load_*_o              clause-table write (valid/addr/data)
//   att_load_*_o             address-translation-table write
//   ucb_load_*_o             unsat-clause-buffer write
//   start_o, done_i          solver handshake
//   unsat_count_i            Controller unsat buffer count
//   busy_o                   not idle in HDR, or a write still pending
//   result_valid_o           one-cycle result strobe
//   result_sat_o             unsat count was zero at done
//   result_count_o           captured unsat count
//   solve_cycles_o           saturating cycles from start to done
//
// state  | meaning
// HDR    | waiting for a header word
// BEAT   | collecting data beats for the current table entries
// START  | pulse start_o, clear cycle counter
// WAIT   | counting cycles until done_i
// REPORT | strobe result_valid_o
module sat_problem_loader #(
  parameter  int NSAT                      = 3,
  parameter  int NUM_VARIABLES             = 2048,
  parameter  int MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter  int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  localparam int VAW       = $clog2(NUM_VARIABLES),
  localparam int LAW       = VAW + 1,
  localparam int CLW       = NSAT * LAW,
  localparam int CTW       = LAW * (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP,
  localparam int ATW       = VAW + MAX_CLAUSE_MEMBERSHIP,
  localparam int UAW       = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  sat_problem_loader_if.slave  cmd,
  output logic                 ct_load_valid_o,
  output logic [VAW-1:0]       ct_load_addr_o,
  output logic [CTW-1:0]       ct_load_data_o,
  output logic                 att_load_valid_o,
  output logic [LAW:0]         att_load_addr_o,
  output logic [ATW-1:0]       att_load_data_o,
  output logic                 ucb_load_valid_o,
  output logic [UAW-1:0]       ucb_load_addr_o,
  output logic [CLW-1:0]       ucb_load_data_o,
  output logic                 start_o,
  input  logic                 done_i,
  input  logic [10:0]          unsat_count_i,
  output logic                 busy_o,
  output logic                 result_valid_o,
  output logic                 result_sat_o,
  output logic [10:0]          result_count_o,
  output logic [31:0]          solve_cycles_o
);

  localparam int CT_BEATS  = (CTW + 31) / 32;
  localparam int ATT_BEATS = (ATW + 31) / 32;
  localparam int UCB_BEATS = (CLW + 31) / 32;
  localparam int MAXB = (CT_BEATS > UCB_BEATS)
                      ? ((CT_BEATS > ATT_BEATS) ? CT_BEATS : ATT_BEATS)
                      : ((UCB_BEATS > ATT_BEATS) ? UCB_BEATS : ATT_BEATS);
  localparam int ASMW = MAXB * 32;
  localparam int BW   = $clog2(MAXB + 1);
  // One address register wide enough for every table; each table's output
  // takes only its low bits, so truncation and wrap come for free.
  localparam int AW   = (LAW + 1 > UAW) ? LAW + 1 : UAW;

  typedef enum logic [2:0] {HDR, BEAT, START, WAIT, REPORT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       tbl_q, tbl_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [15:0]      rem_q, rem_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [ASMW-1:0]  asm_q, asm_d;
  logic             ct_valid_q, ct_valid_d;
  logic [VAW-1:0]   ct_addr_q, ct_addr_d;
  logic [CTW-1:0]   ct_data_q, ct_data_d;
  logic             att_valid_q, att_valid_d;
  logic [LAW:0]     att_addr_q, att_addr_d;
  logic [ATW-1:0]   att_data_q, att_data_d;
  logic             ucb_valid_q, ucb_valid_d;
  logic [UAW-1:0]   ucb_addr_q, ucb_addr_d;
  logic [CLW-1:0]   ucb_data_q, ucb_data_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      solve_q, solve_d;
  logic             res_sat_q, res_sat_d;
  logic [10:0]      res_count_q, res_count_d;

  logic             s_ready;
  logic             fire;
  logic [BW-1:0]    last_beat;
  logic [12:0]      hdr_base;
  logic             unused_hdr_bit;

  assign unused_hdr_bit = cmd.s_data[29];
  assign hdr_base       = cmd.s_data[28:16];
  assign s_ready        = (state_q == HDR) || (state_q == BEAT);
  assign fire           = cmd.s_valid && s_ready;

  always_comb begin
    case (tbl_q)
      2'd0:    last_beat = BW'(CT_BEATS - 1);
      2'd1:    last_beat = BW'(ATT_BEATS - 1);
      default: last_beat = BW'(UCB_BEATS - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      tbl_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      asm_q       <= '0;
      ct_valid_q  <= 1'b0;
      ct_addr_q   <= '0;
      ct_data_q   <= '0;
      att_valid_q <= 1'b0;
      att_addr_q  <= '0;
      att_data_q  <= '0;
      ucb_valid_q <= 1'b0;
      ucb_addr_q  <= '0;
      ucb_data_q  <= '0;
      cyc_q       <= '0;
      solve_q     <= '0;
      res_sat_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      asm_q       <= asm_d;
      ct_valid_q  <= ct_valid_d;
      ct_addr_q   <= ct_addr_d;
      ct_data_q   <= ct_data_d;
      att_valid_q <= att_valid_d;
      att_addr_q  <= att_addr_d;
      att_data_q  <= att_data_d;
      ucb_valid_q <= ucb_valid_d;
      ucb_addr_q  <= ucb_addr_d;
      ucb_data_q  <= ucb_data_d;
      cyc_q       <= cyc_d;
      solve_q     <= solve_d;
      res_sat_q   <= res_sat_d;
      res_count_q <= res_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beat_d      = beat_q;
    asm_d       = asm_q;
    ct_valid_d  = 1'b0;
    ct_addr_d   = ct_addr_q;
    ct_data_d   = ct_data_q;
    att_valid_d = 1'b0;
    att_addr_d  = att_addr_q;
    att_data_d  = att_data_q;
    ucb_valid_d = 1'b0;
    ucb_addr_d  = ucb_addr_q;
    ucb_data_d  = ucb_data_q;
    cyc_d       = cyc_q;
    solve_d     = solve_q;
    res_sat_d   = res_sat_q;
    res_count_d = res_count_q;

    case (state_q)
      HDR: begin
        if (fire) begin
          if (cmd.s_data[31:30] == 2'd3) begin
            state_d = START;
          end else if (cmd.s_data[15:0] != 16'd0) begin
            state_d = BEAT;
            tbl_d   = cmd.s_data[31:30];
            rem_d   = cmd.s_data[15:0];
            beat_d  = '0;
            addr_d  = AW'(hdr_base);
          end
        end
      end

      BEAT: begin
        if (fire) begin
          // LSB-first packing; the final beat is merged here so the output
          // register sees the complete entry in the same cycle.
          asm_d[32*int'(beat_q) +: 32] = cmd.s_data;
          if (beat_q == last_beat) begin
            beat_d = '0;
            case (tbl_q)
              2'd0: begin
                ct_valid_d = 1'b1;
                ct_addr_d  = addr_q[VAW-1:0];
                ct_data_d  = asm_d[CTW-1:0];
              end
              2'd1: begin
                att_valid_d = 1'b1;
                att_addr_d  = addr_q[LAW:0];
                att_data_d  = asm_d[ATW-1:0];
              end
              default: begin
                ucb_valid_d = 1'b1;
                ucb_addr_d  = addr_q[UAW-1:0];
                ucb_data_d  = asm_d[CLW-1:0];
              end
            endcase
            addr_d = addr_q + AW'(1);
            if (rem_q == 16'd1) begin
              state_d = HDR;
            end else begin
              rem_d = rem_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      START: begin
        cyc_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (done_i) begin
          res_count_d = unsat_count_i;
          res_sat_d   = (unsat_count_i == 11'd0);
          solve_d     = cyc_q;
          state_d     = REPORT;
        end else if (cyc_q != 32'hFFFF_FFFF) begin
          cyc_d = cyc_q + 32'd1;
        end
      end

      REPORT: begin
        state_d = HDR;
      end

      default: begin
        state_d = HDR;
      end
    endcase
  end

  assign cmd.s_ready      = s_ready;
  assign ct_load_valid_o  = ct_valid_q;
  assign ct_load_addr_o   = ct_addr_q;
  assign ct_load_data_o   = ct_data_q;
  assign att_load_valid_o = att_valid_q;
  assign att_load_addr_o  = att_addr_q;
  assign att_load_data_o  = att_data_q;
  assign ucb_load_valid_o = ucb_valid_q;
  assign ucb_load_addr_o  = ucb_addr_q;
  assign ucb_load_data_o  = ucb_data_q;
  assign start_o          = (state_q == START);
  assign result_valid_o   = (state_q == REPORT);
  assign result_sat_o     = res_sat_q;
  assign result_count_o   = res_count_q;
  assign solve_cycles_o   = solve_q;
  assign busy_o           = (state_q != HDR) || ct_valid_q || att_valid_q || ucb_valid_q;

endmodule
